div_issue_ctrl: RTL and testbench
=================================

# div_issue_ctrl

Front-end for the EX-stage divide path. Accepts DIV/DIVU from EX, latches operands, converts them to magnitudes plus sign flags, issues a one-cycle start to `divider_control`, and stalls the pipeline while the divide runs. It captures the single-cycle done result, writes HI/LO, and handles flush and divide-by-zero.

## Interface
Parameters:
- none. Constants live in the package.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `ex_div_valid` in 1: a DIV/DIVU is present in EX.
- `ex_div_signed` in 1: 1 = DIV, 0 = DIVU.
- `ex_rs` in 32: dividend.
- `ex_rt` in 32: divisor.
- `flush` in 1: kill the EX instruction and any in-flight divide.
- `div_begin` out 1: one-cycle start to the divider.
- `div_sign` out 1: quotient is negative.
- `div_dividend_sign` out 1: remainder is negative.
- `div_dividend` out 32: dividend magnitude, registered.
- `div_divisor` out 32: divisor magnitude, registered.
- `div_quotient` in 32: signed-corrected quotient, valid only while `div_done`.
- `div_remainder` in 32: signed-corrected remainder, valid only while `div_done`.
- `div_done` in 1: one-cycle completion pulse from the divider.
- `stall` out 1: hold IF/ID/EX.
- `hilo_we` out 1: one-cycle HI/LO write enable.
- `hi_wdata` out 32: remainder.
- `lo_wdata` out 32: quotient.

## Operation
FSM states: IDLE, ISSUE, WAIT, WRITE, DRAIN.

- **IDLE**
  - Accepts when `ex_div_valid & !flush`. On accept it latches the magnitudes, the sign flags, and `ex_rs`.
  - Divisor ≠ 0 → ISSUE.
  - Divisor = 0 → WRITE directly. This is the bypass: no `div_begin`, HI = `ex_rs`, LO = 32'hFFFF_FFFF.
- **Magnitudes**
  - `mag(x) = (signed & x[31]) ? ~x+1 : x`.
  - 32'h8000_0000 stays 32'h8000_0000 and is correct as unsigned.
- **Sign flags**
  - `div_sign = signed & (rs[31]^rt[31])`.
  - `div_dividend_sign = signed & rs[31]`.
- **ISSUE**
  - `div_begin = !flush`.
  - flush → IDLE.
  - Otherwise → WAIT.
- **WAIT**
  - On `div_done`: capture quotient and remainder into result registers → WRITE.
  - On flush (with no `div_done` that cycle) → DRAIN.
- **WRITE**
  - `hilo_we = !flush`, driving the result registers → IDLE.
- **DRAIN**
  - The divider cannot be aborted.
  - Wait for `div_done`, discard the result → IDLE.
- **Operand stability:** `div_dividend`/`div_divisor` are held constant from ISSUE until `div_done`, because the divider's inputs are always valid.
- **Stall:** `stall = (IDLE & ex_div_valid & !flush) | ISSUE | WAIT | (DRAIN & ex_div_valid)`. It is deasserted in WRITE so the instruction retires from EX that cycle. WRITE never re-accepts.
- **Reset:** state = IDLE. All outputs are 0: `div_begin`, `div_sign`, `div_dividend_sign`, `div_dividend`, `div_divisor`, `stall`, `hilo_we`, `hi_wdata`, `lo_wdata`. The divider shares `rst`, so reset mid-divide is clean.

## Timing
- Accept cycle A, ISSUE at A+1.
  - The divider loads its 34-count at the end of A+1.
  - `div_done` is high at A+36.
  - WRITE and `hilo_we` at A+37.
- `stall` is high for cycles A..A+36 (37 cycles).
- Correctness depends only on `div_done`, never on the nominal count.
- Zero-divisor bypass: `stall` at A only, `hilo_we` at A+1.
- `div_begin` is never asserted while `div_done` is high. ISSUE is at least 2 cycles after any done, so a divider restart is impossible.
- Flush arriving the same cycle as `div_done` in WAIT: go to WRITE, where the same-cycle flush rule applies. Only a flush in WRITE itself suppresses `hilo_we`.
- A new DIV during DRAIN is stalled. It is accepted in the first IDLE cycle, i.e. the cycle after `div_done`.

## Structure
- Package `div_pkg` holds:
  - `typedef enum logic [2:0] div_state_t` (IDLE, ISSUE, WAIT, WRITE, DRAIN);
  - `DIV_ZERO_LO = 32'hFFFF_FFFF`;
  - `DIV_NOMINAL_LAT = 36` (bench use only).
- One combinational sub-module, `div_operand_prep`: takes rs, rt and signed; produces the two magnitudes, the two sign flags, and divisor_is_zero.

## Test plan
- DIVU 100/7 → `div_begin` at A+1, `stall` A..A+36, `hilo_we` at A+37 with HI=2, LO=14.
- DIV 0xFFFFFFF9/2 → `div_dividend`=7, `div_sign`=1, `div_dividend_sign`=1; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → `div_dividend`=0x80000000, `div_divisor`=1; LO=0x80000000, HI=0.
- DIV 5/0 → no `div_begin`, `stall` at A only, `hilo_we` at A+1 with HI=5, LO=0xFFFFFFFF.
- Flush at A+10, then a new DIVU 9/3 presented from A+11 → no `hilo_we` for the first divide. `stall` stays high through A+36; the second divide is accepted at A+37 and writes HI=0, LO=3 at A+74.
- `rst` asserted at A+20 → next cycle all outputs 0, state IDLE. A subsequent DIVU 8/2 completes normally with LO=4, HI=0.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the divide issue path
package div_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DRAIN} div_state_t;
  localparam logic [31:0] DIV_ZERO_LO = 32'hFFFF_FFFF;
  localparam int DIV_NOMINAL_LAT = 36;
endpackage

// File: rtl/div_operand_prep.sv
// div_operand_prep: converts DIV/DIVU operands to magnitudes plus result sign flags
module div_operand_prep (
  input  logic        i_signed,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [31:0] o_rs_mag,
  output logic [31:0] o_rt_mag,
  output logic        o_quot_neg,
  output logic        o_rem_neg,
  output logic        o_rt_zero
);
  logic w_rs_neg, w_rt_neg;
  assign w_rs_neg = i_signed & i_rs[31];
  assign w_rt_neg = i_signed & i_rt[31];
  // 0x8000_0000 negates to itself, which is already the right unsigned magnitude
  assign o_rs_mag = w_rs_neg ? ~i_rs + 32'd1 : i_rs;
  assign o_rt_mag = w_rt_neg ? ~i_rt + 32'd1 : i_rt;
  assign o_quot_neg = w_rs_neg ^ w_rt_neg;
  assign o_rem_neg = w_rs_neg;
  assign o_rt_zero = ~|i_rt;
endmodule

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage divide front-end issuing to the divider and writing HI/LO
module div_issue_ctrl
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_div_valid,
  input  logic        ex_div_signed,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        flush,
  output logic        div_begin,
  output logic        div_sign,
  output logic        div_dividend_sign,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_done,
  output logic        stall,
  output logic        hilo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);
  div_state_t r_state;
  logic [31:0] r_dividend, r_divisor, r_hi, r_lo;
  logic r_sign, r_dsign;
  logic [31:0] w_rs_mag, w_rt_mag;
  logic w_quot_neg, w_rem_neg, w_rt_zero, w_accept;

  div_operand_prep u_prep (
    .i_signed   (ex_div_signed),
    .i_rs       (ex_rs),
    .i_rt       (ex_rt),
    .o_rs_mag   (w_rs_mag),
    .o_rt_mag   (w_rt_mag),
    .o_quot_neg (w_quot_neg),
    .o_rem_neg  (w_rem_neg),
    .o_rt_zero  (w_rt_zero)
  );

  assign w_accept = (r_state == IDLE) & ex_div_valid & ~flush;

  // operands only load on accept, so they stay stable for the whole divide
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_dividend <= '0;
      r_divisor <= '0;
      r_sign <= 1'b0;
      r_dsign <= 1'b0;
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_dividend <= w_rs_mag;
          r_divisor <= w_rt_mag;
          r_sign <= w_quot_neg;
          r_dsign <= w_rem_neg;
          if (w_rt_zero) begin
            r_hi <= ex_rs;
            r_lo <= DIV_ZERO_LO;
            r_state <= WRITE;
          end else r_state <= ISSUE;
        end
        ISSUE: r_state <= flush ? IDLE : WAIT;
        WAIT: if (div_done) begin
          r_hi <= div_remainder;
          r_lo <= div_quotient;
          r_state <= WRITE;
        end else if (flush) r_state <= DRAIN;
        WRITE: r_state <= IDLE;
        DRAIN: if (div_done) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign div_begin = (r_state == ISSUE) & ~flush;
  assign hilo_we = (r_state == WRITE) & ~flush;
  assign stall = w_accept | (r_state == ISSUE) | (r_state == WAIT) | ((r_state == DRAIN) & ex_div_valid);
  assign div_sign = r_sign;
  assign div_dividend_sign = r_dsign;
  assign div_dividend = r_dividend;
  assign div_divisor = r_divisor;
  assign hi_wdata = r_hi;
  assign lo_wdata = r_lo;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: vector, corner-sequence and random checks of div_issue_ctrl with a divider model
module tb_div_issue_ctrl;
  import div_pkg::*;
  logic clk = 1'b0, rst = 1'b1, ex_div_valid = 1'b0, ex_div_signed = 1'b0, flush = 1'b0, div_done = 1'b0;
  logic [31:0] ex_rs = '0, ex_rt = '0, div_quotient = '0, div_remainder = '0;
  logic div_begin, div_sign, div_dividend_sign, stall, hilo_we;
  logic [31:0] div_dividend, div_divisor, hi_wdata, lo_wdata;
  int n_tests = 0, n_fail = 0;
  logic s_begin, s_stall, s_we, s_sg, s_ds;
  logic [31:0] s_hi, s_lo, s_dd, s_dv;
  int dv_cnt = 0;
  logic [31:0] m_dd, m_dv;
  logic m_sg, m_ds;
  int we_cnt, first_we, begin_cnt, last_begin, stall_cnt;
  logic [31:0] w_hi, w_lo, c_dd, c_dv;
  logic c_sg, c_ds;

  typedef struct {
    bit sg;
    logic [31:0] rs, rt, hi, lo, dd, dv;
    bit qs, rn;
  } vec_t;

  div_issue_ctrl dut (
    .clk(clk), .rst(rst), .ex_div_valid(ex_div_valid), .ex_div_signed(ex_div_signed),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .div_begin(div_begin), .div_sign(div_sign),
    .div_dividend_sign(div_dividend_sign), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
    .stall(stall), .hilo_we(hilo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // one clock: sample outputs mid-cycle, then advance the divider model past the edge
  task automatic cyc();
    #3;
    s_begin = div_begin; s_stall = stall; s_we = hilo_we; s_hi = hi_wdata; s_lo = lo_wdata;
    s_dd = div_dividend; s_dv = div_divisor; s_sg = div_sign; s_ds = div_dividend_sign;
    @(posedge clk);
    #1;
    div_done = 1'b0;
    div_quotient = $urandom;
    div_remainder = $urandom;
    if (rst) dv_cnt = 0;
    else if (s_begin) begin
      dv_cnt = 34;
      m_dd = s_dd; m_dv = s_dv; m_sg = s_sg; m_ds = s_ds;
    end else if (dv_cnt > 0) begin
      dv_cnt--;
      if (dv_cnt == 0) begin
        div_done = 1'b1;
        div_quotient = m_sg ? -(m_dd / m_dv) : m_dd / m_dv;
        div_remainder = m_ds ? -(m_dd % m_dv) : m_dd % m_dv;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_begin"}, 32'(s_begin), 0);
    chk({tag, "_sign"}, 32'(s_sg), 0);
    chk({tag, "_dsign"}, 32'(s_ds), 0);
    chk({tag, "_dividend"}, s_dd, 0);
    chk({tag, "_divisor"}, s_dv, 0);
    chk({tag, "_stall"}, 32'(s_stall), 0);
    chk({tag, "_we"}, 32'(s_we), 0);
    chk({tag, "_hi"}, s_hi, 0);
    chk({tag, "_lo"}, s_lo, 0);
  endtask

  // EX-stage driver: holds the DIV while stalled, drops it on retire/flush/reset
  task automatic seq(input bit sg, input logic [31:0] rs, input logic [31:0] rt, input int fl_at,
                     input int rst_at, input bit second, input int ncyc);
    bit live1, live2;
    live1 = 1'b1; live2 = 1'b0;
    we_cnt = 0; first_we = -1; begin_cnt = 0; last_begin = -1; stall_cnt = 0;
    w_hi = 'x; w_lo = 'x;
    for (int n = 0; n < ncyc; n++) begin
      rst = (n == rst_at);
      flush = (n == fl_at);
      if (n == rst_at) live1 = 1'b0;
      if (second && fl_at >= 0 && n == fl_at + 1) live2 = 1'b1;
      ex_div_valid = live1 | live2;
      ex_div_signed = live1 ? sg : 1'b0;
      ex_rs = live1 ? rs : 32'd9;
      ex_rt = live1 ? rt : 32'd3;
      cyc();
      if (s_we) begin
        we_cnt++;
        if (first_we < 0) begin first_we = n; w_hi = s_hi; w_lo = s_lo; end
      end
      if (s_begin) begin begin_cnt++; last_begin = n; end
      if (s_stall) stall_cnt++;
      if (n == 1) begin c_dd = s_dd; c_dv = s_dv; c_sg = s_sg; c_ds = s_ds; end
      if (rst_at >= 0 && n == rst_at + 1) chk_zero("midrst");
      if (flush) live1 = 1'b0;
      else if (!s_stall && ex_div_valid) begin live1 = 1'b0; live2 = 1'b0; end
    end
    flush = 1'b0; rst = 1'b0; ex_div_valid = 1'b0;
  endtask

  task automatic check_run(input string tag, input bit zero, input logic [31:0] hi, input logic [31:0] lo,
                           input logic [31:0] dd, input logic [31:0] dv, input bit qs, input bit rn);
    chk({tag, "_we_cnt"}, we_cnt, 1);
    chk({tag, "_we_at"}, first_we, zero ? 1 : DIV_NOMINAL_LAT + 1);
    chk({tag, "_hi"}, w_hi, hi);
    chk({tag, "_lo"}, w_lo, lo);
    chk({tag, "_begin_cnt"}, begin_cnt, zero ? 0 : 1);
    chk({tag, "_begin_at"}, last_begin, zero ? -1 : 1);
    chk({tag, "_stall_cyc"}, stall_cnt, zero ? 1 : DIV_NOMINAL_LAT + 1);
    chk({tag, "_dividend"}, c_dd, dd);
    chk({tag, "_divisor"}, c_dv, dv);
    chk({tag, "_sign"}, 32'(c_sg), 32'(qs));
    chk({tag, "_dsign"}, 32'(c_ds), 32'(rn));
  endtask

  initial begin
    vec_t tbl[8];
    logic [31:0] sp[6];
    tbl[0] = '{1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 32'd100, 32'd7, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd7, 32'd2, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'h8000_0000, 32'd1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'd0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 32'd7, 32'd2, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd16, 32'd0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0};
    sp = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    chk_zero("por");
    foreach (tbl[i])
      begin
        seq(tbl[i].sg, tbl[i].rs, tbl[i].rt, -1, -1, 1'b0, 40);
        check_run($sformatf("vec%0d", i), tbl[i].rt == 0, tbl[i].hi, tbl[i].lo, tbl[i].dd, tbl[i].dv,
                  tbl[i].qs, tbl[i].rn);
      end
    // flush mid-divide, next DIVU 9/3 waits behind the drain
    seq(1'b0, 32'd100, 32'd7, 10, -1, 1'b1, 80);
    chk("drain_we_cnt", we_cnt, 1);
    chk("drain_we_at", first_we, 74);
    chk("drain_hi", w_hi, 0);
    chk("drain_lo", w_lo, 3);
    chk("drain_begin_cnt", begin_cnt, 2);
    chk("drain_begin_at", last_begin, 38);
    chk("drain_stall_cyc", stall_cnt, 74);
    // reset mid-divide, then a normal divide
    seq(1'b0, 32'd100, 32'd7, -1, 20, 1'b0, 30);
    chk("rst_we_cnt", we_cnt, 0);
    chk("rst_begin_cnt", begin_cnt, 1);
    seq(1'b0, 32'd8, 32'd2, -1, -1, 1'b0, 40);
    check_run("post_rst", 1'b0, 32'd0, 32'd4, 32'd8, 32'd2, 1'b0, 1'b0);
    // flush in the accept cycle: nothing happens
    seq(1'b0, 32'd100, 32'd7, 0, -1, 1'b0, 40);
    chk("fl_acc_stall", stall_cnt, 0);
    chk("fl_acc_begin", begin_cnt, 0);
    chk("fl_acc_we", we_cnt, 0);
    // flush in ISSUE suppresses the start
    seq(1'b0, 32'd100, 32'd7, 1, -1, 1'b0, 42);
    chk("fl_iss_begin", begin_cnt, 0);
    chk("fl_iss_we", we_cnt, 0);
    chk("fl_iss_stall", stall_cnt, 2);
    // flush coinciding with done still writes
    seq(1'b0, 32'd100, 32'd7, 36, -1, 1'b0, 42);
    chk("fl_done_we_cnt", we_cnt, 1);
    chk("fl_done_we_at", first_we, 37);
    chk("fl_done_hi", w_hi, 2);
    chk("fl_done_lo", w_lo, 14);
    // flush in WRITE suppresses the write
    seq(1'b0, 32'd100, 32'd7, 37, -1, 1'b0, 42);
    chk("fl_wr_we", we_cnt, 0);
    chk("fl_wr_stall", stall_cnt, 37);
    seq(1'b1, 32'd5, 32'd0, 1, -1, 1'b0, 6);
    chk("fl_zwr_we", we_cnt, 0);
    chk("fl_zwr_begin", begin_cnt, 0);
    chk("fl_zwr_stall", stall_cnt, 1);
    // random operands against an arithmetic reference
    for (int i = 0; i < 25; i++) begin
      bit sg, qs, rn;
      logic [31:0] rs, rt, hi, lo, dd, dv;
      longint a, b, q, r, t;
      sg = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : $urandom;
      case ($urandom_range(0, 4))
        0: rt = 32'd0;
        1: rt = sp[$urandom_range(0, 5)];
        2: rt = 32'($urandom_range(1, 20));
        default: rt = $urandom;
      endcase
      a = sg ? longint'($signed(rs)) : longint'({32'd0, rs});
      b = sg ? longint'($signed(rt)) : longint'({32'd0, rt});
      if (b == 0) begin
        hi = rs; lo = 32'hFFFF_FFFF;
      end else begin
        q = a / b; r = a % b;
        hi = r[31:0]; lo = q[31:0];
      end
      t = (a < 0) ? -a : a; dd = t[31:0];
      t = (b < 0) ? -b : b; dv = t[31:0];
      qs = (a < 0) != (b < 0);
      rn = a < 0;
      seq(sg, rs, rt, -1, -1, 1'b0, 39);
      check_run($sformatf("rnd%0d", i), rt == 0, hi, lo, dd, dv, qs, rn);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
